ysyx_22041752_divider_p: RTL and testbench

YSYX_22041752_DIVIDER_P -- requirements
Module: ysyx_22041752_divider_p

---
 rtl/ysyx_22041752_divider_p.sv | 203 ++++++++++++++++++++
 tb/tb_ysyx_22041752_divider_p.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041752_divider_p.sv
// Iterative restoring radix-2 divider with signed/unsigned and 32-bit word-op support.
// Divide-by-zero and signed overflow finish one cycle after accept, bypassing the iteration.
module ysyx_22041752_divider_p #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned WORD_EN = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            div_valid,
    output logic            div_ready,
    input  logic            div_signed,
    input  logic            div_word,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            busy
);

    localparam bit          WordOk = (WORD_EN != 0) && (XLEN == 64);
    localparam int unsigned CW     = $clog2(XLEN);

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StIter,
        StFix,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] qacc_q, qacc_d;
    logic            signed_q, signed_d;
    logic            word_q, word_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rmd_q, rmd_d;

    logic            accept;
    logic            acc_word;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] a_dvd;
    logic [XLEN-1:0] a_dvs;
    logic [XLEN-1:0] min_neg;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] qfix;
    logic [XLEN-1:0] rfix;

    // Extend bit 31 upward when sgn is set, otherwise clear the upper half.
    function automatic logic [XLEN-1:0] ext_word(input logic [XLEN-1:0] v, input logic sgn);
        logic [XLEN-1:0] r;
        r = v;
        for (int i = 32; i < XLEN; i++) begin
            r[i] = sgn & v[31];
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        qacc_d   = qacc_q;
        signed_d = signed_q;
        word_d   = word_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        quot_d   = quot_q;
        rmd_d    = rmd_q;

        accept   = div_valid && (state_q == StIdle) && !flush;
        acc_word = div_word && WordOk;
        a_dvd    = acc_word ? ext_word(dividend, div_signed) : dividend;
        a_dvs    = acc_word ? ext_word(divisor, div_signed) : divisor;
        min_neg  = '0;
        if (acc_word) begin
            min_neg[31] = 1'b1;
            min_neg     = ext_word(min_neg, 1'b1);
        end else begin
            min_neg[XLEN-1] = 1'b1;
        end
        div_zero = (a_dvs == '0);
        overflow = div_signed && (a_dvd == min_neg) && (a_dvs == '1);

        shifted  = {rem_q, dvd_q[cnt_q]};
        diff     = shifted - {1'b0, dvs_q};
        qfix     = qneg_q ? (~qacc_q + 1'b1) : qacc_q;
        rfix     = rneg_q ? (~rem_q + 1'b1) : rem_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    dvd_d    = a_dvd;
                    dvs_d    = a_dvs;
                    signed_d = div_signed;
                    word_d   = acc_word;
                    if (div_zero) begin
                        quot_d  = '1;
                        rmd_d   = acc_word ? ext_word(a_dvd, 1'b1) : a_dvd;
                        state_d = StDone;
                    end else if (overflow) begin
                        quot_d  = a_dvd;
                        rmd_d   = '0;
                        state_d = StDone;
                    end else begin
                        state_d = StPrep;
                    end
                end
            end
            StPrep: begin
                dvd_d   = (signed_q && dvd_q[XLEN-1]) ? (~dvd_q + 1'b1) : dvd_q;
                dvs_d   = (signed_q && dvs_q[XLEN-1]) ? (~dvs_q + 1'b1) : dvs_q;
                qneg_d  = signed_q && (dvd_q[XLEN-1] ^ dvs_q[XLEN-1]);
                rneg_d  = signed_q && dvd_q[XLEN-1];
                rem_d   = '0;
                qacc_d  = '0;
                cnt_d   = word_q ? CW'(31) : CW'(XLEN - 1);
                state_d = StIter;
            end
            StIter: begin
                // A clear top bit means the trial subtraction did not borrow.
                if (!diff[XLEN]) begin
                    rem_d         = diff[XLEN-1:0];
                    qacc_d[cnt_q] = 1'b1;
                end else begin
                    rem_d = shifted[XLEN-1:0];
                end
                if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StFix: begin
                quot_d  = word_q ? ext_word(qfix, 1'b1) : qfix;
                rmd_d   = word_q ? ext_word(rfix, 1'b1) : rfix;
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Flush wins over everything and must not publish a result.
        if (flush) begin
            state_d = StIdle;
            quot_d  = quot_q;
            rmd_d   = rmd_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            qacc_q   <= '0;
            signed_q <= 1'b0;
            word_q   <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            quot_q   <= '0;
            rmd_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            qacc_q   <= qacc_d;
            signed_q <= signed_d;
            word_q   <= word_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            quot_q   <= quot_d;
            rmd_q    <= rmd_d;
        end
    end

    assign div_ready = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign quotient  = quot_q;
    assign remainder = rmd_q;

endmodule

// File: tb/tb_ysyx_22041752_divider_p.sv
// Directed self-checking bench for ysyx_22041752_divider_p at XLEN=64 with word ops enabled.
module tb_ysyx_22041752_divider_p;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        div_valid = 1'b0;
    logic        div_ready;
    logic        div_signed = 1'b0;
    logic        div_word = 1'b0;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int Bound = 200;

    ysyx_22041752_divider_p #(
        .XLEN    (64),
        .WORD_EN (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_signed (div_signed),
        .div_word   (div_word),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Drive one request, scramble operands after accept, return latency and results.
    // Latency 1 means out_valid is already high at the first edge after the accept edge.
    task automatic do_op(input logic sgn, input logic wrd, input logic [63:0] a,
                         input logic [63:0] b, output int lat,
                         output logic [63:0] q, output logic [63:0] r);
        @(negedge clk);
        div_valid  = 1'b1;
        div_signed = sgn;
        div_word   = wrd;
        dividend   = a;
        divisor    = b;
        out_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        div_valid  = 1'b0;
        div_signed = ~sgn;
        div_word   = ~wrd;
        dividend   = 64'hDEAD_BEEF_0BAD_F00D;
        divisor    = 64'h1;
        lat = 1;
        while (!out_valid && lat < Bound) begin
            @(negedge clk);
            lat++;
        end
        q = quotient;
        r = remainder;
    endtask

    task automatic take;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: out_valid=%b busy=%b required 0 0", out_valid, busy);
        end
        n_checks++;
        if (quotient !== 64'h0 || remainder !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data: q=%h r=%h required 0 0", quotient, remainder);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (div_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: div_ready=%b required 1", div_ready);
        end
    endtask

    task automatic test_unsigned_backpressure;
        int lat;
        logic [63:0] q, r;
        do_op(1'b0, 1'b0, 64'd100, 64'd7, lat, q, r);
        n_checks++;
        if (lat !== 67) begin
            n_fail++;
            $display("FAIL udiv_latency: got %0d required 67", lat);
        end
        n_checks++;
        if (q !== 64'd14 || r !== 64'd2) begin
            n_fail++;
            $display("FAIL udiv_100_7: q=%h r=%h required 14 2", q, r);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || quotient !== 64'd14 || remainder !== 64'd2) begin
                n_fail++;
                $display("FAIL hold_%0d: v=%b q=%h r=%h required 1 14 2",
                         i, out_valid, quotient, remainder);
            end
        end
        take();
        n_checks++;
        if (out_valid !== 1'b0 || div_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release: v=%b rdy=%b required 0 1", out_valid, div_ready);
        end
    endtask

    task automatic test_signed;
        int lat;
        logic [63:0] q, r;
        do_op(1'b1, 1'b0, -64'sd7, 64'd2, lat, q, r);
        take();
        n_checks++;
        if (q !== 64'hFFFF_FFFF_FFFF_FFFD || r !== 64'hFFFF_FFFF_FFFF_FFFF || lat !== 67) begin
            n_fail++;
            $display("FAIL sdiv_m7_2: q=%h r=%h lat=%0d required fffffffffffffffd ffffffffffffffff 67",
                     q, r, lat);
        end
        do_op(1'b1, 1'b0, 64'd100, -64'sd7, lat, q, r);
        take();
        n_checks++;
        if (q !== 64'hFFFF_FFFF_FFFF_FFF2 || r !== 64'd2) begin
            n_fail++;
            $display("FAIL sdiv_100_m7: q=%h r=%h required fffffffffffffff2 2", q, r);
        end
        do_op(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, lat, q, r);
        take();
        n_checks++;
        if (q !== 64'h7FFF_FFFF_FFFF_FFFF || r !== 64'd1) begin
            n_fail++;
            $display("FAIL udiv_max_2: q=%h r=%h required 7fffffffffffffff 1", q, r);
        end
    endtask

    task automatic test_special;
        int lat;
        logic [63:0] q, r;
        do_op(1'b0, 1'b0, 64'd5, 64'd0, lat, q, r);
        take();
        n_checks++;
        if (q !== 64'hFFFF_FFFF_FFFF_FFFF || r !== 64'd5 || lat !== 1) begin
            n_fail++;
            $display("FAIL udiv_by_zero: q=%h r=%h lat=%0d required all-ones 5 1", q, r, lat);
        end
        do_op(1'b1, 1'b0, 64'd5, 64'd0, lat, q, r);
        take();
        n_checks++;
        if (q !== 64'hFFFF_FFFF_FFFF_FFFF || r !== 64'd5 || lat !== 1) begin
            n_fail++;
            $display("FAIL sdiv_by_zero: q=%h r=%h lat=%0d required all-ones 5 1", q, r, lat);
        end
        do_op(1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, q, r);
        take();
        n_checks++;
        if (q !== 64'h8000_0000_0000_0000 || r !== 64'd0 || lat !== 1) begin
            n_fail++;
            $display("FAIL sdiv_overflow: q=%h r=%h lat=%0d required 8000000000000000 0 1",
                     q, r, lat);
        end
    endtask

    task automatic test_word;
        int lat;
        logic [63:0] q, r;
        do_op(1'b0, 1'b1, 64'hFFFF_FFFF_0000_0010, 64'd3, lat, q, r);
        take();
        n_checks++;
        if (q !== 64'd5 || r !== 64'd1 || lat !== 35) begin
            n_fail++;
            $display("FAIL word_udiv: q=%h r=%h lat=%0d required 5 1 35", q, r, lat);
        end
        do_op(1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, lat, q, r);
        take();
        n_checks++;
        if (q !== 64'hFFFF_FFFF_8000_0000 || r !== 64'd0 || lat !== 1) begin
            n_fail++;
            $display("FAIL word_overflow: q=%h r=%h lat=%0d required ffffffff80000000 0 1",
                     q, r, lat);
        end
        do_op(1'b1, 1'b1, 64'h1234_5678_FFFF_FF9C, 64'h0000_0000_0000_0007, lat, q, r);
        take();
        n_checks++;
        if (q !== 64'hFFFF_FFFF_FFFF_FFF2 || r !== 64'hFFFF_FFFF_FFFF_FFFE || lat !== 35) begin
            n_fail++;
            $display("FAIL word_sdiv: q=%h r=%h lat=%0d required fffffffffffffff2 fffffffffffffffe 35",
                     q, r, lat);
        end
        do_op(1'b0, 1'b1, 64'h1234_5678_8000_0001, 64'hABCD_0000_0000_0000, lat, q, r);
        take();
        n_checks++;
        if (q !== 64'hFFFF_FFFF_FFFF_FFFF || r !== 64'hFFFF_FFFF_8000_0001 || lat !== 1) begin
            n_fail++;
            $display("FAIL word_by_zero: q=%h r=%h lat=%0d required all-ones ffffffff80000001 1",
                     q, r, lat);
        end
    endtask

    task automatic test_flush;
        int lat;
        int seen;
        logic [63:0] q, r;
        @(negedge clk);
        div_valid = 1'b1;
        div_signed = 1'b0;
        div_word = 1'b0;
        dividend = 64'd1000;
        divisor = 64'd3;
        @(posedge clk);
        @(negedge clk);
        div_valid = 1'b0;
        // Now in PREP; nine more edges reach the 10th ITER cycle.
        repeat (10) @(negedge clk);
        flush = 1'b1;
        div_valid = 1'b1;
        dividend = 64'd77;
        divisor = 64'd7;
        @(negedge clk);
        flush = 1'b0;
        div_valid = 1'b0;
        n_checks++;
        if (div_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: rdy=%b v=%b busy=%b required 1 0 0",
                     div_ready, out_valid, busy);
        end
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL flush_no_result: out_valid seen %0d cycles required 0", seen);
        end
        do_op(1'b0, 1'b0, 64'd9, 64'd4, lat, q, r);
        take();
        n_checks++;
        if (q !== 64'd2 || r !== 64'd1 || lat !== 67) begin
            n_fail++;
            $display("FAIL after_flush: q=%h r=%h lat=%0d required 2 1 67", q, r, lat);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [63:0] q, r;
        do_op(1'b0, 1'b0, 64'd1000, 64'd10, lat, q, r);
        // Offer the next request while taking the result: it must not be accepted yet.
        out_ready = 1'b1;
        div_valid = 1'b1;
        dividend = 64'd17;
        divisor = 64'd5;
        div_signed = 1'b0;
        div_word = 1'b0;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        div_valid = 1'b0;
        n_checks++;
        if (q !== 64'd100 || r !== 64'd0 || div_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: q=%h r=%h rdy=%b v=%b required 100 0 1 0",
                     q, r, div_ready, out_valid);
        end
        do_op(1'b0, 1'b0, 64'd17, 64'd5, lat, q, r);
        take();
        n_checks++;
        if (q !== 64'd3 || r !== 64'd2 || lat !== 67) begin
            n_fail++;
            $display("FAIL b2b_second: q=%h r=%h lat=%0d required 3 2 67", q, r, lat);
        end
    endtask

    task automatic test_async_reset;
        int seen;
        @(negedge clk);
        div_valid = 1'b1;
        div_signed = 1'b0;
        div_word = 1'b0;
        dividend = 64'd100;
        divisor = 64'd7;
        @(posedge clk);
        @(negedge clk);
        div_valid = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || quotient !== 64'd0 || remainder !== 64'd0) begin
            n_fail++;
            $display("FAIL async_reset: v=%b busy=%b q=%h r=%h required 0 0 0 0",
                     out_valid, busy, quotient, remainder);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (div_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_release: div_ready=%b required 1", div_ready);
        end
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL async_no_result: out_valid seen %0d cycles required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_backpressure();
        test_signed();
        test_special();
        test_word();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
